// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Shared widths and the result bundle type for the writeback stage.
// Revision : 1.0
// ============================================================================
package wb_arbiter_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int DATA_BITS    = 64;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                 inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]  data;
    logic [MAX_OPERANDS-1:0]                 data_valid;
  } wb_bundle_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_fifo
// Brief    : Per-FU result bundle FIFO with push/pop/flush and next-count output.
// Revision : 1.0
// ============================================================================
module wb_arbiter_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  wb_bundle_t          push_data,
  input  logic                pop,
  output logic [CNT_BITS-1:0] count_next,
  output wb_bundle_t          head,
  output logic                empty,
  output logic                overflow
);

  localparam int PTR_BITS = $clog2(DEPTH);

  wb_bundle_t          r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                w_full;
  logic                w_pop_ok;
  logic                w_push_ok;

  assign w_full    = (r_count == CNT_BITS'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop & ~empty & ~flush;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign w_push_ok = push & (~w_full | w_pop_ok) & ~flush;
  assign overflow  = push & w_full & ~w_pop_ok & ~flush;
  assign head      = r_mem[r_rd_ptr];

  always_comb begin
    count_next = r_count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = r_count + CNT_BITS'(w_push_ok) - CNT_BITS'(w_pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= count_next;
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Writeback arbiter: buffers FU results and round-robin retires up to
//            WB_WIDTH bundles per cycle to the PRF, wakeup and ROB.
// Revision : 1.0
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FU_COUNT     = 4,
  parameter int WB_WIDTH     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 flush,
  input  logic [FU_COUNT-1:0]                                  fu_out_valid,
  input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]                fu_out_inst_id,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  fu_out_prn,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] fu_out_data,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                fu_out_data_valid,
  output logic [FU_COUNT-1:0]                                  fu_stall,
  output logic [WB_WIDTH-1:0][MAX_OPERANDS-1:0]                prf_wen,
  output logic [WB_WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  prf_wprn,
  output logic [WB_WIDTH-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] prf_wdata,
  output logic [WB_WIDTH-1:0]                                  cmp_valid,
  output logic [WB_WIDTH-1:0][INST_ID_BITS-1:0]                cmp_inst_id,
  output logic                                                 overflow_err
);

  localparam int FU_BITS  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                  r_rst_sync;
  logic                        w_rst_n;
  wb_bundle_t                  w_head [FU_COUNT];
  logic [FU_COUNT-1:0]         w_empty;
  logic [FU_COUNT-1:0]         w_ovf;
  logic [CNT_BITS-1:0]         w_count_next [FU_COUNT];
  logic [FU_COUNT-1:0]         w_pop;
  logic [WB_WIDTH-1:0]         w_lane_vld;
  logic [WB_WIDTH-1:0][FU_BITS-1:0] w_lane_fu;
  wb_bundle_t                  w_lane_bundle [WB_WIDTH];
  logic [FU_BITS-1:0]          w_rr_next;
  logic [FU_BITS-1:0]          r_rr_ptr;
  logic [FU_COUNT-1:0]         r_stall;
  logic                        r_overflow;

  // Assertion is immediate; release waits two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar i = 0; i < FU_COUNT; i++) begin : g_fifo
    wb_bundle_t w_in;

    assign w_in.inst_id    = fu_out_inst_id[i];
    assign w_in.prn        = fu_out_prn[i];
    assign w_in.data       = fu_out_data[i];
    assign w_in.data_valid = fu_out_data_valid[i];

    wb_arbiter_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .CNT_BITS (CNT_BITS)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (w_rst_n),
      .flush      (flush),
      .push       (fu_out_valid[i]),
      .push_data  (w_in),
      .pop        (w_pop[i]),
      .count_next (w_count_next[i]),
      .head       (w_head[i]),
      .empty      (w_empty[i]),
      .overflow   (w_ovf[i])
    );
  end

  // Each lane claims the first non-empty, not-yet-claimed FIFO in scan order
  // from rr_ptr, so lane k carries the k-th grant.
  always_comb begin
    logic [FU_BITS-1:0] idx;
    logic               found;
    idx        = '0;
    found      = 1'b0;
    w_pop      = '0;
    w_lane_vld = '0;
    w_lane_fu  = '0;
    w_rr_next  = r_rr_ptr;
    for (int k = 0; k < WB_WIDTH; k++) begin
      found = 1'b0;
      for (int i = 0; i < FU_COUNT; i++) begin
        if (int'(r_rr_ptr) + i >= FU_COUNT) begin
          idx = FU_BITS'(int'(r_rr_ptr) + i - FU_COUNT);
        end else begin
          idx = FU_BITS'(int'(r_rr_ptr) + i);
        end
        if (!found && !w_empty[idx] && !w_pop[idx]) begin
          found         = 1'b1;
          w_pop[idx]    = 1'b1;
          w_lane_vld[k] = 1'b1;
          w_lane_fu[k]  = idx;
          w_rr_next     = (idx == FU_BITS'(FU_COUNT - 1)) ? '0 : idx + FU_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < WB_WIDTH; k++) begin
      w_lane_bundle[k] = w_head[w_lane_fu[k]];
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      cmp_valid   <= '0;
      cmp_inst_id <= '0;
      prf_wen     <= '0;
      prf_wprn    <= '0;
      prf_wdata   <= '0;
    end else begin
      for (int k = 0; k < WB_WIDTH; k++) begin
        if (w_lane_vld[k] && !flush) begin
          cmp_valid[k]   <= 1'b1;
          cmp_inst_id[k] <= w_lane_bundle[k].inst_id;
          prf_wen[k]     <= w_lane_bundle[k].data_valid;
          prf_wprn[k]    <= w_lane_bundle[k].prn;
          prf_wdata[k]   <= w_lane_bundle[k].data;
        end else begin
          // Idle lanes keep address/data/id stable to avoid needless toggling.
          cmp_valid[k] <= 1'b0;
          prf_wen[k]   <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rr_ptr   <= '0;
      r_stall    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rr_ptr <= flush ? '0 : w_rr_next;
      for (int i = 0; i < FU_COUNT; i++) begin
        r_stall[i] <= !flush &&
                      ((CNT_BITS'(FIFO_DEPTH) - w_count_next[i]) <= CNT_BITS'(STALL_MARGIN));
      end
      if (|w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign fu_stall     = r_stall;
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter at WB_WIDTH 2 and 1.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush;
  logic [3:0]                 fu_out_valid;
  logic [3:0][5:0]            fu_out_inst_id;
  logic [3:0][2:0][5:0]       fu_out_prn;
  logic [3:0][2:0][63:0]      fu_out_data;
  logic [3:0][2:0]            fu_out_data_valid;

  logic [3:0]                 fu_stall_a;
  logic [1:0][2:0]            prf_wen_a;
  logic [1:0][2:0][5:0]       prf_wprn_a;
  logic [1:0][2:0][63:0]      prf_wdata_a;
  logic [1:0]                 cmp_valid_a;
  logic [1:0][5:0]            cmp_inst_id_a;
  logic                       overflow_err_a;

  logic [3:0]                 fu_stall_b;
  logic [0:0][2:0]            prf_wen_b;
  logic [0:0][2:0][5:0]       prf_wprn_b;
  logic [0:0][2:0][63:0]      prf_wdata_b;
  logic [0:0]                 cmp_valid_b;
  logic [0:0][5:0]            cmp_inst_id_b;
  logic                       overflow_err_b;

  int n_checks = 0;
  int n_errors = 0;
  int seen   [64];
  int pushed [64];

  always #5 clk = ~clk;

  wb_arbiter #(.FU_COUNT(4), .WB_WIDTH(2), .FIFO_DEPTH(4), .STALL_MARGIN(2)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_out_valid(fu_out_valid), .fu_out_inst_id(fu_out_inst_id), .fu_out_prn(fu_out_prn),
    .fu_out_data(fu_out_data), .fu_out_data_valid(fu_out_data_valid),
    .fu_stall(fu_stall_a), .prf_wen(prf_wen_a), .prf_wprn(prf_wprn_a), .prf_wdata(prf_wdata_a),
    .cmp_valid(cmp_valid_a), .cmp_inst_id(cmp_inst_id_a), .overflow_err(overflow_err_a)
  );

  wb_arbiter #(.FU_COUNT(4), .WB_WIDTH(1), .FIFO_DEPTH(4), .STALL_MARGIN(2)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_out_valid(fu_out_valid), .fu_out_inst_id(fu_out_inst_id), .fu_out_prn(fu_out_prn),
    .fu_out_data(fu_out_data), .fu_out_data_valid(fu_out_data_valid),
    .fu_stall(fu_stall_b), .prf_wen(prf_wen_b), .prf_wprn(prf_wprn_b), .prf_wdata(prf_wdata_b),
    .cmp_valid(cmp_valid_b), .cmp_inst_id(cmp_inst_id_b), .overflow_err(overflow_err_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush             = 1'b0;
    fu_out_valid      = '0;
    fu_out_inst_id    = '0;
    fu_out_prn        = '0;
    fu_out_data       = '0;
    fu_out_data_valid = '0;
  endtask

  task automatic set_fu(input int fu, input logic [5:0] id);
    fu_out_valid[fu]      = 1'b1;
    fu_out_inst_id[fu]    = id;
    fu_out_data_valid[fu] = 3'b101;
    for (int s = 0; s < 3; s++) begin
      fu_out_prn[fu][s]  = id + 6'(s);
      fu_out_data[fu][s] = {50'h0, id, 8'(s)};
    end
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic clear_book();
    for (int i = 0; i < 64; i++) begin
      seen[i]   = 0;
      pushed[i] = 0;
    end
  endtask

  // Logs every completion on the single-lane instance.
  task automatic step_b();
    tick();
    if (cmp_valid_b[0]) seen[cmp_inst_id_b[0]]++;
  endtask

  initial begin
    int b_cycle;
    int b_count;
    int na;
    int nc;
    int bad;
    int total;
    int any_cmp;

    idle();
    #1 rst = 1'b0;
    tick();
    tick();
    check_eq("rst_cmp_valid", 64'(cmp_valid_a), 64'(0));
    check_eq("rst_prf_wen", 64'(prf_wen_a), 64'(0));
    check_eq("rst_stall", 64'(fu_stall_a), 64'(0));
    check_eq("rst_overflow", 64'(overflow_err_a), 64'(0));
    rst = 1'b1;
    repeat (3) tick();

    // Single bundle with a partially valid slot set.
    fu_out_valid[1]      = 1'b1;
    fu_out_inst_id[1]    = 6'd5;
    fu_out_prn[1][0]     = 6'd7;
    fu_out_data[1][0]    = 64'hAA;
    fu_out_prn[1][1]     = 6'd9;
    fu_out_data[1][1]    = 64'hBB;
    fu_out_prn[1][2]     = 6'd63;
    fu_out_data[1][2]    = 64'hCC;
    fu_out_data_valid[1] = 3'b011;
    tick();
    idle();
    check_eq("t1_latency", 64'(cmp_valid_a), 64'(0));
    tick();
    check_eq("t1_cmp_valid", 64'(cmp_valid_a), 64'(2'b01));
    check_eq("t1_inst_id", 64'(cmp_inst_id_a[0]), 64'(5));
    check_eq("t1_wen", 64'(prf_wen_a[0]), 64'(3'b011));
    check_eq("t1_prn0", 64'(prf_wprn_a[0][0]), 64'(7));
    check_eq("t1_prn1", 64'(prf_wprn_a[0][1]), 64'(9));
    check_eq("t1_data0", prf_wdata_a[0][0], 64'hAA);
    check_eq("t1_data1", prf_wdata_a[0][1], 64'hBB);
    check_eq("t1_lane1_wen", 64'(prf_wen_a[1]), 64'(0));
    tick();
    check_eq("t1_drop_valid", 64'(cmp_valid_a), 64'(0));
    check_eq("t1_hold_id", 64'(cmp_inst_id_a[0]), 64'(5));

    // Four simultaneous pushes retire two per cycle in index order.
    do_reset();
    for (int f = 0; f < 4; f++) set_fu(f, 6'(f + 1));
    tick();
    idle();
    tick();
    check_eq("t2_c1_valid", 64'(cmp_valid_a), 64'(2'b11));
    check_eq("t2_c1_lane0", 64'(cmp_inst_id_a[0]), 64'(1));
    check_eq("t2_c1_lane1", 64'(cmp_inst_id_a[1]), 64'(2));
    tick();
    check_eq("t2_c2_valid", 64'(cmp_valid_a), 64'(2'b11));
    check_eq("t2_c2_lane0", 64'(cmp_inst_id_a[0]), 64'(3));
    check_eq("t2_c2_lane1", 64'(cmp_inst_id_a[1]), 64'(4));
    tick();
    check_eq("t2_idle", 64'(cmp_valid_a), 64'(0));
    set_fu(0, 6'd10);
    set_fu(3, 6'd13);
    tick();
    idle();
    tick();
    check_eq("t2_rr_lane0", 64'(cmp_inst_id_a[0]), 64'(10));
    check_eq("t2_rr_lane1", 64'(cmp_inst_id_a[1]), 64'(13));

    // Single lane: a lone FU3 bundle is not starved by a busy FU0.
    do_reset();
    b_cycle = 0;
    b_count = 0;
    for (int j = 1; j <= 10; j++) begin
      idle();
      if (j <= 8) set_fu(0, 6'(j - 1));
      if (j == 3) set_fu(3, 6'd63);
      tick();
      if (cmp_valid_b[0] && cmp_inst_id_b[0] == 6'd63) begin
        b_cycle = j;
        b_count++;
      end
    end
    check_eq("t3_fu3_cycle", 64'(b_cycle), 64'(4));
    check_eq("t3_fu3_once", 64'(b_count), 64'(1));

    // Single lane, two FUs that back off on fu_stall.
    do_reset();
    clear_book();
    na = 0;
    nc = 32;
    for (int j = 1; j <= 12; j++) begin
      idle();
      if (!fu_stall_b[0]) begin
        set_fu(0, 6'(na));
        pushed[na]++;
        na++;
      end
      if (!fu_stall_b[2]) begin
        set_fu(2, 6'(nc));
        pushed[nc]++;
        nc++;
      end
      step_b();
      if (j == 1) check_eq("t4_stall2_early", 64'(fu_stall_b[2]), 64'(0));
      if (j == 2) check_eq("t4_stall2_rise", 64'(fu_stall_b[2]), 64'(1));
    end
    idle();
    repeat (10) step_b();
    bad = 0;
    total = 0;
    for (int i = 0; i < 64; i++) begin
      if (seen[i] != pushed[i]) bad++;
      total += seen[i];
    end
    check_eq("t4_overflow", 64'(overflow_err_b), 64'(0));
    check_eq("t4_pushes", 64'(na + nc - 32), 64'(14));
    check_eq("t4_completions", 64'(total), 64'(14));
    check_eq("t4_once_each", 64'(bad), 64'(0));

    // Flush with three queued bundles and a push in the flush cycle.
    do_reset();
    set_fu(0, 6'd1);
    set_fu(1, 6'd2);
    set_fu(2, 6'd3);
    tick();
    idle();
    flush = 1'b1;
    set_fu(3, 6'd42);
    tick();
    idle();
    check_eq("t5_cmp_valid", 64'(cmp_valid_a), 64'(0));
    check_eq("t5_prf_wen", 64'(prf_wen_a), 64'(0));
    any_cmp = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (cmp_valid_a != 2'b00) any_cmp++;
    end
    check_eq("t5_nothing_left", 64'(any_cmp), 64'(0));
    check_eq("t5_stall", 64'(fu_stall_a), 64'(0));
    set_fu(1, 6'd7);
    tick();
    idle();
    tick();
    check_eq("t5_post_valid", 64'(cmp_valid_a), 64'(2'b01));
    check_eq("t5_post_id", 64'(cmp_inst_id_a[0]), 64'(7));

    // Single lane, FU0/FU1 ignore fu_stall: b7 lands on a full FIFO.
    do_reset();
    clear_book();
    for (int j = 1; j <= 8; j++) begin
      idle();
      set_fu(0, 6'(j - 1));
      set_fu(1, 6'(32 + j - 1));
      step_b();
      if (j == 7) check_eq("t6_ovf_before", 64'(overflow_err_b), 64'(0));
      if (j == 8) check_eq("t6_ovf_set", 64'(overflow_err_b), 64'(1));
    end
    idle();
    repeat (10) step_b();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (seen[i] != 1) bad++;
      if (i < 7 && seen[32 + i] != 1) bad++;
    end
    check_eq("t6_dropped", 64'(seen[39]), 64'(0));
    check_eq("t6_others_once", 64'(bad), 64'(0));
    check_eq("t6_ovf_sticky", 64'(overflow_err_b), 64'(1));

    // Asynchronous reset in the middle of a cycle with lanes active.
    for (int f = 0; f < 4; f++) set_fu(f, 6'(f + 20));
    tick();
    idle();
    tick();
    check_eq("t6_pre_rst_valid", 64'(cmp_valid_a), 64'(2'b11));
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_cmp_valid", 64'(cmp_valid_a), 64'(0));
    check_eq("t6_rst_prf_wen", 64'(prf_wen_a), 64'(0));
    check_eq("t6_rst_cmp_b", 64'(cmp_valid_b), 64'(0));
    check_eq("t6_rst_ovf_b", 64'(overflow_err_b), 64'(0));
    check_eq("t6_rst_stall_b", 64'(fu_stall_b), 64'(0));
    tick();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
